// File: rtl/rv32_mc_control.sv
// ----------------------------------------------------------------------------
// rv32_mc_control
//
// Multi-cycle RV32I control unit. An FSM steps each instruction through
// FETCH, DECODE, EXEC, MEM and WB, and drives the datapath control fields,
// the register enables and the memory request strobes. Both memory ports
// use a variable-latency request/ack handshake with a bus timeout. Illegal
// instructions and timeouts enter a sticky TRAP state that only rst leaves.
//
// Optional feature: define RV32M_EN to add the M-extension. This adds an MDU
// state and the ports o_mdu_start, o_mdu_op and i_mdu_done. When RV32M_EN is
// not defined, funct7=0x01 on OP is illegal.
//
// Parameters
//   TIMEOUT  max cycles a memory request may wait for ack (0 = no timeout)
//   ALU_W    width of o_alu_sel
//
// Ports
//   i_clk, i_rst              clock, synchronous active-high reset
//   i_instr                   instruction register contents
//   i_breq, i_brlt            branch comparator results (EXEC)
//   i_imem_ack, i_dmem_ack    memory completes the request this cycle
//   o_imem_req, o_dmem_req    fetch / data memory request
//   o_mem_rw, o_mem_funct3    1 = store; access size/sign during MEM
//   o_ir_wen, o_pc_wen,
//   o_reg_wen                 register enables
//   o_pc_sel                  0 = PC+4, 1 = ALU result
//   o_imm_sel                 0 I, 1 S, 2 B, 3 J, 4 U
//   o_br_un, o_a_sel, o_b_sel unsigned compare, A = PC, B = immediate
//   o_alu_sel                 ALU operation
//   o_wb_sel                  0 mem, 1 ALU, 2 PC+4, 3 MDU
//   o_trap, o_trap_cause      sticky fault flag; 1 illegal, 2 imem, 3 dmem
//   o_mdu_start, o_mdu_op,
//   i_mdu_done                MDU handshake (RV32M_EN only)
// ----------------------------------------------------------------------------
module rv32_mc_control #(
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned ALU_W   = 4
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [31:0]      i_instr,
   input  logic             i_breq,
   input  logic             i_brlt,
   input  logic             i_imem_ack,
   input  logic             i_dmem_ack,
`ifdef RV32M_EN
   input  logic             i_mdu_done,
   output logic             o_mdu_start,
   output logic [2:0]       o_mdu_op,
`endif
   output logic             o_imem_req,
   output logic             o_dmem_req,
   output logic             o_mem_rw,
   output logic [2:0]       o_mem_funct3,
   output logic             o_ir_wen,
   output logic             o_pc_wen,
   output logic             o_reg_wen,
   output logic             o_pc_sel,
   output logic [2:0]       o_imm_sel,
   output logic             o_br_un,
   output logic             o_a_sel,
   output logic             o_b_sel,
   output logic [ALU_W-1:0] o_alu_sel,
   output logic [1:0]       o_wb_sel,
   output logic             o_trap,
   output logic [1:0]       o_trap_cause
);

   // FSM states
   localparam logic [2:0] S_FETCH  = 3'd0;
   localparam logic [2:0] S_DECODE = 3'd1;
   localparam logic [2:0] S_EXEC   = 3'd2;
   localparam logic [2:0] S_MEM    = 3'd3;
   localparam logic [2:0] S_WB     = 3'd4;
   localparam logic [2:0] S_TRAP   = 3'd5;
`ifdef RV32M_EN
   localparam logic [2:0] S_MDU    = 3'd6;
`endif

   // Opcodes
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   // ALU operations
   localparam logic [ALU_W-1:0] ALU_ADD    = ALU_W'(0);
   localparam logic [ALU_W-1:0] ALU_SUB    = ALU_W'(1);
   localparam logic [ALU_W-1:0] ALU_SLL    = ALU_W'(2);
   localparam logic [ALU_W-1:0] ALU_SLT    = ALU_W'(3);
   localparam logic [ALU_W-1:0] ALU_SLTU   = ALU_W'(4);
   localparam logic [ALU_W-1:0] ALU_XOR    = ALU_W'(5);
   localparam logic [ALU_W-1:0] ALU_SRL    = ALU_W'(6);
   localparam logic [ALU_W-1:0] ALU_SRA    = ALU_W'(7);
   localparam logic [ALU_W-1:0] ALU_OR     = ALU_W'(8);
   localparam logic [ALU_W-1:0] ALU_AND    = ALU_W'(9);
   localparam logic [ALU_W-1:0] ALU_PASS_B = ALU_W'(11);

   // Trap causes
   localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
   localparam logic [1:0] CAUSE_IMEM    = 2'd2;
   localparam logic [1:0] CAUSE_DMEM    = 2'd3;

   // Counter only has to hold 0..TIMEOUT-1; reaching TIMEOUT means trap.
   localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

   logic [2:0]       r_state;
   logic [2:0]       w_state_d;
   logic [CNT_W-1:0] r_cnt;
   logic             r_trap;
   logic [1:0]       r_trap_cause;
   logic [1:0]       w_cause_d;

   logic [6:0]       w_opcode;
   logic [2:0]       w_funct3;
   logic [6:0]       w_funct7;
   logic             w_is_lui, w_is_auipc, w_is_jal, w_is_jalr, w_is_branch;
   logic             w_is_load, w_is_store, w_is_opimm, w_is_op, w_is_mdu;
   logic             w_f7_std;
   logic             w_legal;
   logic             w_taken;
   logic [ALU_W-1:0] w_alu_f3;
   logic             w_wait;
   logic             w_tmo;
   logic             w_unused_instr;

   assign w_opcode = i_instr[6:0];
   assign w_funct3 = i_instr[14:12];
   assign w_funct7 = i_instr[31:25];

   // Register indices are consumed by the datapath, not here.
   assign w_unused_instr = ^{i_instr[24:15], i_instr[11:7]};

   assign w_is_lui    = (w_opcode == OPC_LUI);
   assign w_is_auipc  = (w_opcode == OPC_AUIPC);
   assign w_is_jal    = (w_opcode == OPC_JAL);
   assign w_is_jalr   = (w_opcode == OPC_JALR);
   assign w_is_branch = (w_opcode == OPC_BRANCH);
   assign w_is_load   = (w_opcode == OPC_LOAD);
   assign w_is_store  = (w_opcode == OPC_STORE);
   assign w_is_opimm  = (w_opcode == OPC_OPIMM);
   assign w_is_op     = (w_opcode == OPC_OP);
   assign w_f7_std    = (w_funct7 == 7'h00) || (w_funct7 == 7'h20);
`ifdef RV32M_EN
   assign w_is_mdu    = w_is_op && (w_funct7 == 7'h01);
`else
   assign w_is_mdu    = 1'b0;
`endif

   // Instruction legality, evaluated in DECODE
   always_comb begin
      w_legal = 1'b0;
      case (w_opcode)
         OPC_LUI, OPC_AUIPC, OPC_JAL: w_legal = 1'b1;
         OPC_JALR:   w_legal = (w_funct3 == 3'b000);
         OPC_BRANCH: w_legal = (w_funct3[2:1] != 2'b01);
         OPC_LOAD:   w_legal = (w_funct3 != 3'b011) && (w_funct3 != 3'b110) &&
                               (w_funct3 != 3'b111);
         OPC_STORE:  w_legal = !w_funct3[2] && (w_funct3 != 3'b011);
         // Only the shift-immediates carry a funct7 field.
         OPC_OPIMM:  w_legal = (w_funct3[1:0] == 2'b01) ? w_f7_std : 1'b1;
         OPC_OP:     w_legal = w_f7_std || w_is_mdu;
         default:    w_legal = 1'b0;
      endcase
   end

   // funct3 -> ALU op; instr[30] picks SUB (register form only) and SRA.
   always_comb begin
      w_alu_f3 = ALU_ADD;
      case (w_funct3)
         3'b000:  w_alu_f3 = (w_is_op && i_instr[30]) ? ALU_SUB : ALU_ADD;
         3'b001:  w_alu_f3 = ALU_SLL;
         3'b010:  w_alu_f3 = ALU_SLT;
         3'b011:  w_alu_f3 = ALU_SLTU;
         3'b100:  w_alu_f3 = ALU_XOR;
         3'b101:  w_alu_f3 = i_instr[30] ? ALU_SRA : ALU_SRL;
         3'b110:  w_alu_f3 = ALU_OR;
         default: w_alu_f3 = ALU_AND;
      endcase
   end

   // funct3[2] selects lt vs eq, funct3[0] inverts (BNE, BGE, BGEU).
   assign w_taken = w_funct3[2] ? (i_brlt ^ w_funct3[0]) : (i_breq ^ w_funct3[0]);

   assign w_wait = ((r_state == S_FETCH) && !i_imem_ack) ||
                   ((r_state == S_MEM)   && !i_dmem_ack);
   assign w_tmo  = (TIMEOUT != 0) && w_wait && (r_cnt == CNT_W'(TIMEOUT - 1));

   // Next state
   always_comb begin
      w_state_d = r_state;
      w_cause_d = 2'd0;
      case (r_state)
         S_FETCH: begin
            if (i_imem_ack) begin
               w_state_d = S_DECODE;
            end else if (w_tmo) begin
               w_state_d = S_TRAP;
               w_cause_d = CAUSE_IMEM;
            end
         end
         S_DECODE: begin
            if (w_legal) begin
               w_state_d = S_EXEC;
            end else begin
               w_state_d = S_TRAP;
               w_cause_d = CAUSE_ILLEGAL;
            end
         end
         S_EXEC: begin
            if (w_is_branch) begin
               w_state_d = S_FETCH;
            end else if (w_is_load || w_is_store) begin
               w_state_d = S_MEM;
`ifdef RV32M_EN
            end else if (w_is_mdu) begin
               w_state_d = S_MDU;
`endif
            end else begin
               w_state_d = S_WB;
            end
         end
         S_MEM: begin
            if (i_dmem_ack) begin
               w_state_d = w_is_load ? S_WB : S_FETCH;
            end else if (w_tmo) begin
               w_state_d = S_TRAP;
               w_cause_d = CAUSE_DMEM;
            end
         end
         S_WB:   w_state_d = S_FETCH;
         S_TRAP: w_state_d = S_TRAP;
`ifdef RV32M_EN
         S_MDU:  w_state_d = i_mdu_done ? S_WB : S_MDU;
`endif
         default: w_state_d = S_FETCH;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= S_FETCH;
         r_cnt        <= '0;
         r_trap       <= 1'b0;
         r_trap_cause <= 2'd0;
      end else begin
         r_state <= w_state_d;
         // Leaving a state clears the count, so every FETCH/MEM starts at 0.
         if (w_state_d != r_state) begin
            r_cnt <= '0;
         end else if (w_wait && (TIMEOUT != 0)) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
         if ((w_state_d == S_TRAP) && (r_state != S_TRAP)) begin
            r_trap       <= 1'b1;
            r_trap_cause <= w_cause_d;
         end
      end
   end

`ifdef RV32M_EN
   // High from the second MDU cycle on, so o_mdu_start pulses only on entry.
   logic r_mdu_busy;
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_mdu_busy <= 1'b0;
      end else begin
         r_mdu_busy <= (r_state == S_MDU);
      end
   end
`endif

   // Outputs; everything is forced low while rst is high so an aborted
   // instruction writes nothing in the reset cycle.
   always_comb begin
      o_imem_req   = 1'b0;
      o_dmem_req   = 1'b0;
      o_mem_rw     = 1'b0;
      o_mem_funct3 = 3'b000;
      o_ir_wen     = 1'b0;
      o_pc_wen     = 1'b0;
      o_reg_wen    = 1'b0;
      o_pc_sel     = 1'b0;
      o_imm_sel    = 3'd0;
      o_br_un      = 1'b0;
      o_a_sel      = 1'b0;
      o_b_sel      = 1'b0;
      o_alu_sel    = ALU_ADD;
      o_wb_sel     = 2'd0;
      o_trap       = 1'b0;
      o_trap_cause = 2'd0;
`ifdef RV32M_EN
      o_mdu_start  = 1'b0;
      o_mdu_op     = 3'b000;
`endif
      if (!i_rst) begin
         o_trap       = r_trap;
         o_trap_cause = r_trap_cause;

         // ALU fields stay valid through MEM (address) and WB (JAL target).
         if ((r_state == S_EXEC) || (r_state == S_MEM) || (r_state == S_WB)) begin
            if (w_is_lui) begin
               o_imm_sel = 3'd4;
               o_b_sel   = 1'b1;
               o_alu_sel = ALU_PASS_B;
            end else if (w_is_auipc) begin
               o_imm_sel = 3'd4;
               o_a_sel   = 1'b1;
               o_b_sel   = 1'b1;
            end else if (w_is_jal) begin
               o_imm_sel = 3'd3;
               o_a_sel   = 1'b1;
               o_b_sel   = 1'b1;
            end else if (w_is_branch) begin
               o_imm_sel = 3'd2;
               o_a_sel   = 1'b1;
               o_b_sel   = 1'b1;
               o_br_un   = w_funct3[1];
            end else if (w_is_store) begin
               o_imm_sel = 3'd1;
               o_b_sel   = 1'b1;
            end else if (w_is_jalr || w_is_load) begin
               o_b_sel   = 1'b1;
            end else if (w_is_opimm) begin
               o_b_sel   = 1'b1;
               o_alu_sel = w_alu_f3;
            end else if (w_is_op) begin
               o_alu_sel = w_alu_f3;
            end
         end

         case (r_state)
            S_FETCH: begin
               o_imem_req = 1'b1;
               o_ir_wen   = i_imem_ack;
            end
            S_EXEC: begin
               if (w_is_branch) begin
                  o_pc_wen = 1'b1;
                  o_pc_sel = w_taken;
               end
            end
            S_MEM: begin
               o_dmem_req   = 1'b1;
               o_mem_rw     = w_is_store;
               o_mem_funct3 = w_funct3;
               o_pc_wen     = i_dmem_ack && w_is_store;
            end
            S_WB: begin
               o_reg_wen = 1'b1;
               o_pc_wen  = 1'b1;
               if (w_is_jal || w_is_jalr) begin
                  o_pc_sel = 1'b1;
                  o_wb_sel = 2'd2;
               end else if (w_is_load) begin
                  o_wb_sel = 2'd0;
               end else if (w_is_mdu) begin
                  o_wb_sel = 2'd3;
               end else begin
                  o_wb_sel = 2'd1;
               end
            end
`ifdef RV32M_EN
            S_MDU: begin
               o_mdu_start = !r_mdu_busy;
               o_mdu_op    = w_funct3;
            end
`endif
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_rv32_mc_control.sv
// ----------------------------------------------------------------------------
// tb_rv32_mc_control
//
// Directed bench for rv32_mc_control (TIMEOUT = 4). Inputs change 1 ns after
// the rising edge; outputs are sampled 3 ns after it. Cycle numbers in tags
// count from the FETCH cycle of each instruction.
// ----------------------------------------------------------------------------
module tb_rv32_mc_control;

   logic        clk;
   logic        rst;
   logic [31:0] instr;
   logic        breq, brlt, imem_ack, dmem_ack;
   logic        imem_req, dmem_req, mem_rw;
   logic [2:0]  mem_funct3;
   logic        ir_wen, pc_wen, reg_wen, pc_sel;
   logic [2:0]  imm_sel;
   logic        br_un, a_sel, b_sel;
   logic [3:0]  alu_sel;
   logic [1:0]  wb_sel;
   logic        trap;
   logic [1:0]  trap_cause;
`ifdef RV32M_EN
   logic        mdu_done, mdu_start;
   logic [2:0]  mdu_op;
`endif

   int n_tests = 0;
   int n_fail  = 0;
   int cnt;

   localparam logic [31:0] I_ADD   = 32'h002081B3; // add  x3,x1,x2
   localparam logic [31:0] I_LUI   = 32'h123450B7; // lui  x1,0x12345
   localparam logic [31:0] I_JAL   = 32'h000000EF; // jal  x1,0
   localparam logic [31:0] I_BGE   = 32'h0020D463; // bge  x1,x2,8
   localparam logic [31:0] I_BLTU  = 32'h0020E463; // bltu x1,x2,8
   localparam logic [31:0] I_LW    = 32'h0040A283; // lw   x5,4(x1)
   localparam logic [31:0] I_SW    = 32'h0020A223; // sw   x2,4(x1)
   localparam logic [31:0] I_ILL   = 32'h0000007F;
   localparam logic [31:0] I_MUL   = 32'h022081B3; // mul  x3,x1,x2

   rv32_mc_control #(
      .TIMEOUT (4),
      .ALU_W   (4)
   ) u_dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_instr      (instr),
      .i_breq       (breq),
      .i_brlt       (brlt),
      .i_imem_ack   (imem_ack),
      .i_dmem_ack   (dmem_ack),
`ifdef RV32M_EN
      .i_mdu_done   (mdu_done),
      .o_mdu_start  (mdu_start),
      .o_mdu_op     (mdu_op),
`endif
      .o_imem_req   (imem_req),
      .o_dmem_req   (dmem_req),
      .o_mem_rw     (mem_rw),
      .o_mem_funct3 (mem_funct3),
      .o_ir_wen     (ir_wen),
      .o_pc_wen     (pc_wen),
      .o_reg_wen    (reg_wen),
      .o_pc_sel     (pc_sel),
      .o_imm_sel    (imm_sel),
      .o_br_un      (br_un),
      .o_a_sel      (a_sel),
      .o_b_sel      (b_sel),
      .o_alu_sel    (alu_sel),
      .o_wb_sel     (wb_sel),
      .o_trap       (trap),
      .o_trap_cause (trap_cause)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance to 1 ns after the next rising edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Let combinational outputs settle before sampling.
   task automatic settle();
      #2;
   endtask

   initial begin
      rst      = 1'b1;
      instr    = I_ADD;
      breq     = 1'b0;
      brlt     = 1'b0;
      imem_ack = 1'b1;
      dmem_ack = 1'b1;
`ifdef RV32M_EN
      mdu_done = 1'b0;
`endif
      cyc();
      settle();
      check("rst imem_req", imem_req, 0);
      check("rst pc_wen", pc_wen, 0);
      check("rst trap", trap, 0);
      cyc();
      rst = 1'b0;

      // ADD with acks tied high
      settle();
      check("add c0 imem_req", imem_req, 1);
      check("add c0 ir_wen", ir_wen, 1);
      cyc(); settle();
      check("add c1 imem_req", imem_req, 0);
      cyc(); settle();
      check("add c2 reg_wen", reg_wen, 0);
      cyc(); settle();
      check("add c3 reg_wen", reg_wen, 1);
      check("add c3 wb_sel", wb_sel, 1);
      check("add c3 alu_sel", alu_sel, 0);
      check("add c3 pc_wen", pc_wen, 1);
      check("add c3 pc_sel", pc_sel, 0);
      cyc(); settle();
      check("add c4 imem_req", imem_req, 1);

      // LUI
      instr = I_LUI;
      cyc(); cyc(); settle();
      check("lui c2 alu_sel", alu_sel, 11);
      check("lui c2 imm_sel", imm_sel, 4);
      check("lui c2 b_sel", b_sel, 1);
      cyc(); settle();
      check("lui c3 wb_sel", wb_sel, 1);

      // JAL
      cyc(); instr = I_JAL;
      cyc(); cyc(); cyc(); settle();
      check("jal c3 pc_sel", pc_sel, 1);
      check("jal c3 wb_sel", wb_sel, 2);
      check("jal c3 imm_sel", imm_sel, 3);
      check("jal c3 a_sel", a_sel, 1);

      // BGE, brlt=0 -> taken
      cyc(); instr = I_BGE; brlt = 1'b0;
      cyc(); cyc(); settle();
      check("bge nlt pc_wen", pc_wen, 1);
      check("bge nlt pc_sel", pc_sel, 1);
      check("bge nlt br_un", br_un, 0);
      check("bge nlt imm_sel", imm_sel, 2);
      check("bge nlt reg_wen", reg_wen, 0);

      // BGE, brlt=1 -> not taken
      cyc(); brlt = 1'b1;
      settle();
      check("bge lt c0 imem_req", imem_req, 1);
      cyc(); cyc(); settle();
      check("bge lt pc_wen", pc_wen, 1);
      check("bge lt pc_sel", pc_sel, 0);

      // BLTU, brlt=1 -> taken, unsigned
      cyc(); instr = I_BLTU;
      cyc(); cyc(); settle();
      check("bltu pc_sel", pc_sel, 1);
      check("bltu br_un", br_un, 1);

      // LW with dmem_ack 3 cycles late; count hits TIMEOUT-1 as ack arrives
      cyc(); instr = I_LW; brlt = 1'b0; dmem_ack = 1'b0;
      cyc(); cyc(); cnt = 0;
      for (int i = 3; i <= 6; i++) begin
         cyc();
         if (i == 6) dmem_ack = 1'b1;
         settle();
         if (dmem_req) cnt++;
         if (i == 3) begin
            check("lw c3 mem_funct3", mem_funct3, 3'b010);
            check("lw c3 mem_rw", mem_rw, 0);
         end
         if (i == 6) check("lw c6 pc_wen", pc_wen, 0);
      end
      check("lw dmem_req cycles", cnt, 4);
      cyc(); settle();
      check("lw c7 reg_wen", reg_wen, 1);
      check("lw c7 wb_sel", wb_sel, 0);
      check("lw c7 trap", trap, 0);

      // imem timeout
      cyc(); imem_ack = 1'b0; instr = I_ADD;
      settle();
      check("tmo c0 imem_req", imem_req, 1);
      cyc(); cyc(); cyc(); settle();
      check("tmo c3 imem_req", imem_req, 1);
      check("tmo c3 trap", trap, 0);
      cyc(); settle();
      check("tmo c4 trap", trap, 1);
      check("tmo c4 trap_cause", trap_cause, 2);
      check("tmo c4 imem_req", imem_req, 0);
      imem_ack = 1'b1;
      cyc(); settle();
      check("tmo c5 trap", trap, 1);
      check("tmo c5 enables", {ir_wen, pc_wen, reg_wen, dmem_req, imem_req}, 0);
      cyc(); rst = 1'b1; settle();
      check("tmo rst trap", trap, 0);
      cyc(); rst = 1'b0; settle();
      check("tmo post-rst imem_req", imem_req, 1);
      check("tmo post-rst trap", trap, 0);

      // Illegal opcode
      instr = I_ILL;
      cyc(); cyc(); settle();
      check("ill trap", trap, 1);
      check("ill trap_cause", trap_cause, 1);
      cyc(); rst = 1'b1;
      cyc(); rst = 1'b0;

      // SW, reset during MEM
      instr = I_SW; dmem_ack = 1'b0;
      cyc(); cyc(); cyc(); settle();
      check("sw c3 dmem_req", dmem_req, 1);
      check("sw c3 mem_rw", mem_rw, 1);
      rst = 1'b1; dmem_ack = 1'b1; settle();
      check("sw rst pc_wen", pc_wen, 0);
      check("sw rst dmem_req", dmem_req, 0);
      cyc(); rst = 1'b0; settle();
      check("sw post-rst imem_req", imem_req, 1);
      check("sw post-rst ir_wen", ir_wen, 1);

      // SW completes normally
      cyc(); cyc(); cyc(); settle();
      check("sw c3 pc_wen", pc_wen, 1);
      check("sw c3 pc_sel", pc_sel, 0);
      check("sw c3 reg_wen", reg_wen, 0);

      // MUL
      cyc(); instr = I_MUL;
`ifdef RV32M_EN
      cyc(); cyc(); cnt = 0;
      for (int i = 3; i <= 7; i++) begin
         cyc();
         if (i == 7) mdu_done = 1'b1;
         settle();
         if (mdu_start) cnt++;
         if (i == 3) check("mul mdu_op", mdu_op, 0);
      end
      check("mul mdu_start pulses", cnt, 1);
      cyc(); mdu_done = 1'b0; settle();
      check("mul wb_sel", wb_sel, 3);
      check("mul reg_wen", reg_wen, 1);
`else
      cyc(); cyc(); settle();
      check("mul trap", trap, 1);
      check("mul trap_cause", trap_cause, 1);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
